// File: rtl/ic_2504_shift_mem.sv
// Recirculating character memory: the Apple-1 bank of 2504 dynamic shift
// registers folded into a single-port read-first RAM plus a rotating pointer.
// After reset the loop is filled with FILL. Each shift then reads the
// character at the pointer and either recirculates it or replaces it with din.
module ic_2504_shift_mem #(
  parameter int               WIDTH = 6,
  parameter int               DEPTH = 1024,
  parameter logic [WIDTH-1:0] FILL  = 6'h20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     shift_en,
  input  logic                     wr_n,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         q,
  output logic [$clog2(DEPTH)-1:0] pos,
  output logic                     wrap,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            wrap_q, wrap_d;
  logic            busy_q, busy_d;
  // q_valid_q masks the RAM output register, which has no reset of its own,
  // so that q reads 0 from reset until the first shift in RUN.
  logic            q_valid_q, q_valid_d;
  logic [WIDTH-1:0] rd_q;

  logic             mem_we;
  logic             mem_re;
  logic [WIDTH-1:0] mem_wdata;
  logic             at_last;

  logic [WIDTH-1:0] mem [DEPTH];

  assign at_last = (ptr_q == LAST);

  // Next-state logic: the clear sweep, then pointer advance on each shift.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wrap_d    = 1'b0;
    busy_d    = busy_q;
    q_valid_d = q_valid_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = din;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_wdata = FILL;
        if (at_last) begin
          ptr_d   = '0;
          busy_d  = 1'b0;
          state_d = S_RUN;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      S_RUN: begin
        if (shift_en) begin
          mem_re    = 1'b1;
          mem_we    = ~wr_n;
          q_valid_d = 1'b1;
          wrap_d    = at_last;
          ptr_d     = at_last ? '0 : ptr_q + AW'(1);
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Control registers; reset restarts the clear sweep from location 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      ptr_q     <= '0;
      wrap_q    <= 1'b0;
      busy_q    <= 1'b1;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wrap_q    <= wrap_d;
      busy_q    <= busy_d;
      q_valid_q <= q_valid_d;
    end
  end

  // Single-port read-first RAM: the read sees the old word on a same-address write.
  always_ff @(posedge clk) begin
    if (mem_re) begin
      rd_q <= mem[ptr_q];
    end
    if (mem_we) begin
      mem[ptr_q] <= mem_wdata;
    end
  end

  assign q    = q_valid_q ? rd_q : '0;
  assign pos  = ptr_q;
  assign wrap = wrap_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_ic_2504_shift_mem.sv
// Directed bench for ic_2504_shift_mem: a table of single-shift vectors
// plus hand-written multi-revolution and reset sequences.
module tb_ic_2504_shift_mem;

  logic       clk;
  logic       reset;
  logic       shift_en;
  logic       wr_n;
  logic [5:0] din;
  logic [5:0] q;
  logic [9:0] pos;
  logic       wrap;
  logic       busy;

  int errors = 0;
  int checks = 0;

  ic_2504_shift_mem #(.WIDTH(6), .DEPTH(1024), .FILL(6'h20)) dut (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .wr_n     (wr_n),
    .din      (din),
    .q        (q),
    .pos      (pos),
    .wrap     (wrap),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       en;
    logic       wr_n;
    logic [5:0] din;
    logic [5:0] q;
    logic [9:0] pos;
    logic       wrap;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, then return just after the rising edge.
  task automatic step(input logic en, input logic w, input logic [5:0] d);
    @(negedge clk);
    shift_en = en;
    wr_n     = w;
    din      = d;
    @(posedge clk);
    #1;
  endtask

  // Count rising edges until busy drops; q and wrap must stay 0 throughout.
  task automatic wait_clear(input string name);
    int n;
    int bad;
    n   = 0;
    bad = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (q !== 6'h00 || wrap !== 1'b0) bad++;
    end
    chk({name, "_busy_cycles"}, n, 1024);
    chk({name, "_q_wrap_quiet"}, bad, 0);
    chk({name, "_pos_after"}, {22'd0, pos}, 0);
    $display("%s: clear took %0d cycles", name, n);
  endtask

  // Read one full revolution with wr_n=1; every location must hold 6'h20.
  task automatic read_all_fill(input string name);
    int bad;
    bad = 0;
    for (int p = 0; p < 1024; p++) begin
      step(1'b1, 1'b1, 6'h00);
      if (q !== 6'h20) bad++;
    end
    chk(name, bad, 0);
    $display("%s: revolution read, %0d bad locations", name, bad);
  endtask

  // Contents left by the table writes.
  function automatic logic [5:0] rev_exp(input int p);
    case (p)
      1:       return 6'h0A;
      2:       return 6'h15;
      5:       return 6'h01;
      7:       return 6'h3F;
      default: return 6'h20;
    endcase
  endfunction

  initial begin
    int bad;
    int wraps;
    logic [5:0] e;

    // Vectors start at pos 0 right after the clear.
    tbl[0] = '{en:1'b1, wr_n:1'b1, din:6'h00, q:6'h20, pos:10'd1, wrap:1'b0};
    tbl[1] = '{en:1'b0, wr_n:1'b0, din:6'h3F, q:6'h20, pos:10'd1, wrap:1'b0};
    tbl[2] = '{en:1'b1, wr_n:1'b0, din:6'h0A, q:6'h20, pos:10'd2, wrap:1'b0};
    tbl[3] = '{en:1'b1, wr_n:1'b0, din:6'h15, q:6'h20, pos:10'd3, wrap:1'b0};
    tbl[4] = '{en:1'b1, wr_n:1'b1, din:6'h2A, q:6'h20, pos:10'd4, wrap:1'b0};
    tbl[5] = '{en:1'b1, wr_n:1'b1, din:6'h00, q:6'h20, pos:10'd5, wrap:1'b0};
    tbl[6] = '{en:1'b1, wr_n:1'b0, din:6'h01, q:6'h20, pos:10'd6, wrap:1'b0};
    tbl[7] = '{en:1'b1, wr_n:1'b1, din:6'h00, q:6'h20, pos:10'd7, wrap:1'b0};
    tbl[8] = '{en:1'b1, wr_n:1'b0, din:6'h3F, q:6'h20, pos:10'd8, wrap:1'b0};

    reset    = 1'b1;
    shift_en = 1'b0;
    wr_n     = 1'b1;
    din      = 6'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 1);
    chk("rst_pos", {22'd0, pos}, 0);
    chk("rst_q", {26'd0, q}, 0);
    chk("rst_wrap", {31'd0, wrap}, 0);
    reset = 1'b0;

    // Post-reset clear with idle inputs.
    wait_clear("clear1");
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 6'h00);
      if (pos !== 10'd0 || wrap !== 1'b0 || q !== 6'h00 || busy !== 1'b0) bad++;
    end
    chk("idle_after_clear", bad, 0);

    // Table-driven single shifts.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].en, tbl[i].wr_n, tbl[i].din);
      $display("vec %0d en=%b wr_n=%b din=%h -> q=%h pos=%0d wrap=%b",
               i, tbl[i].en, tbl[i].wr_n, tbl[i].din, q, pos, wrap);
      chk($sformatf("vec%0d_q", i), {26'd0, q}, {26'd0, tbl[i].q});
      chk($sformatf("vec%0d_pos", i), {22'd0, pos}, {22'd0, tbl[i].pos});
      chk($sformatf("vec%0d_wrap", i), {31'd0, wrap}, {31'd0, tbl[i].wrap});
    end

    // wr_n held low without shift_en: nothing may move.
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0, 6'h2A);
      if (pos !== 10'd8 || q !== 6'h20 || wrap !== 1'b0) bad++;
    end
    chk("hold_no_shift", bad, 0);

    // Finish revolution 1: untouched locations still hold the fill value.
    bad   = 0;
    wraps = 0;
    for (int p = 8; p < 1024; p++) begin
      step(1'b1, 1'b1, 6'h00);
      if (q !== 6'h20) bad++;
      if (wrap === 1'b1) wraps++;
    end
    chk("rev1_q_fill", bad, 0);
    chk("rev1_wrap_count", wraps, 1);
    chk("rev1_wrap_last", {31'd0, wrap}, 1);
    chk("rev1_pos_wrapped", {22'd0, pos}, 0);
    step(1'b0, 1'b1, 6'h00);
    chk("wrap_one_cycle", {31'd0, wrap}, 0);

    // Revolution 2: written characters emerge exactly one revolution later.
    bad   = 0;
    wraps = 0;
    for (int p = 0; p < 1024; p++) begin
      step(1'b1, 1'b1, 6'h00);
      e = rev_exp(p);
      if (e != 6'h20) chk($sformatf("rev2_pos%0d", p), {26'd0, q}, {26'd0, e});
      else if (q !== 6'h20) bad++;
      if (wrap !== ((p == 1023) ? 1'b1 : 1'b0)) wraps++;
    end
    chk("rev2_fill_rest", bad, 0);
    chk("rev2_wrap_timing", wraps, 0);

    // Revolution 3 up to pos 300: values retained while recirculating.
    for (int p = 0; p < 300; p++) begin
      step(1'b1, 1'b1, 6'h00);
      if (p == 5) chk("rev3_pos5", {26'd0, q}, 6'h01);
      if (p == 7) chk("rev3_pos7", {26'd0, q}, 6'h3F);
    end
    chk("pos_300", {22'd0, pos}, 300);

    // Asynchronous reset mid-run, away from the clock edge.
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("run_rst_busy", {31'd0, busy}, 1);
    chk("run_rst_pos", {22'd0, pos}, 0);
    chk("run_rst_q", {26'd0, q}, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_clear("clear2");
    read_all_fill("after_run_reset");

    // Overwrite everything, then reset in the middle of the clear sweep.
    for (int p = 0; p < 1024; p++) step(1'b1, 1'b0, 6'h11);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (500) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midclear_rst_busy", {31'd0, busy}, 1);
    chk("midclear_rst_pos", {22'd0, pos}, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_clear("clear3");
    read_all_fill("after_midclear_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
